// File: rtl/fir_audio_pkg.sv
// rtl/fir_audio_pkg.sv - constants and FSM encoding shared by the FIR audio input/output controllers
package fir_audio_pkg;

    localparam int OUTPUT_DATA_RATE_DEF = 2267;
    localparam int FRAME_NUM_DEF        = 7100;
    localparam int IN_W_DEF             = 24;
    localparam int DATA_W_DEF           = 16;
    localparam int FIFO_AW_DEF          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-array FIFO with occupancy count; read data shows the head entry
module sync_fifo #(
    parameter int W  = 17,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // The owner never pushes when full or pops when empty, so pointers wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/fir_dout_rx.sv
// rtl/fir_dout_rx.sv - FIR decimator output sink: buffers samples and replays them at a fixed DAC rate
// Optional rounding/saturation on capture is enabled by defining FIR_DOUT_SAT_EN.
module fir_dout_rx
    import fir_audio_pkg::*;
#(
    parameter int IN_W             = IN_W_DEF,
    parameter int DATA_W           = DATA_W_DEF,
    parameter int FIFO_AW          = FIFO_AW_DEF,
    parameter int OUTPUT_DATA_RATE = OUTPUT_DATA_RATE_DEF,
    parameter int FRAME_NUM        = FRAME_NUM_DEF
) (
    input  logic              clk_100m,
    input  logic              rst,
    input  logic              fir_dout_vld,
    input  logic [IN_W-1:0]   fir_dout_data,
    input  logic              fir_dout_last,
    output logic              fir_dout_rdy,
    output logic              dac_vld,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_last,
    output logic [15:0]       frame_cnt,
    output logic              underflow,
    output logic              last_err,
    output logic              sat_flag
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int HALF  = 1 << (FIFO_AW - 1);
    localparam int SH    = IN_W - DATA_W;
    localparam int RW    = (OUTPUT_DATA_RATE > 1) ? $clog2(OUTPUT_DATA_RATE) : 1;

    logic [FIFO_AW:0]   fifo_count;
    logic [DATA_W:0]    fifo_rdata;
    logic [DATA_W-1:0]  conv_data;
    logic               push;
    logic               pop;
    logic               strobe;
    logic               fifo_empty;
    rx_state_t          state;
    logic [17:0]        rx_cnt;
    logic [RW-1:0]      rate_cnt;

    assign fir_dout_rdy = (fifo_count != (FIFO_AW+1)'(DEPTH)) && !rst;
    assign push         = fir_dout_vld && fir_dout_rdy;
    assign fifo_empty   = (fifo_count == '0);
    assign strobe       = (state == RUN) && (rate_cnt == RW'(OUTPUT_DATA_RATE - 1));
    // An empty FIFO at the strobe is an underflow even if a write lands in the same cycle.
    assign pop          = strobe && !fifo_empty;

`ifdef FIR_DOUT_SAT_EN
    logic signed [IN_W:0]   rounded;
    logic signed [DATA_W:0] scaled;
    logic                   conv_clip;
    logic                   unused_round;

    always_comb begin
        rounded   = $signed({fir_dout_data[IN_W-1], fir_dout_data}) + $signed((IN_W+1)'(1 << (SH - 1)));
        scaled    = rounded[IN_W -: DATA_W+1];
        conv_clip = (scaled[DATA_W] != scaled[DATA_W-1]);
        if (!conv_clip)          conv_data = scaled[DATA_W-1:0];
        else if (scaled[DATA_W]) conv_data = {1'b1, {(DATA_W-1){1'b0}}};
        else                     conv_data = {1'b0, {(DATA_W-1){1'b1}}};
    end
    assign unused_round = ^rounded[SH-1:0];

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst)                    sat_flag <= 1'b0;
        else if (push && conv_clip) sat_flag <= 1'b1;
    end
`else
    logic unused_low;
    assign conv_data  = fir_dout_data[IN_W-1 -: DATA_W];
    assign unused_low = ^fir_dout_data[SH-1:0];
    assign sat_flag   = 1'b0;
`endif

    sync_fifo #(
        .W  (DATA_W + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk_100m),
        .rst   (rst),
        .push  (push),
        .wdata ({fir_dout_last, conv_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

    always_ff @(posedge clk_100m or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rate_cnt  <= '0;
            rx_cnt    <= '0;
            dac_vld   <= 1'b0;
            dac_data  <= '0;
            dac_last  <= 1'b0;
            underflow <= 1'b0;
            last_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            dac_vld   <= 1'b0;
            dac_last  <= 1'b0;
            underflow <= 1'b0;
            last_err  <= 1'b0;

            // Framing: tlast must appear exactly on beat FRAME_NUM-1; any mismatch restarts the count.
            if (push) begin
                if (fir_dout_last != (rx_cnt == 18'(FRAME_NUM - 1))) begin
                    last_err <= 1'b1;
                    rx_cnt   <= '0;
                end else if (fir_dout_last) begin
                    rx_cnt <= '0;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (push) state <= PRIME;
                end
                PRIME: begin
                    if (fifo_count >= (FIFO_AW+1)'(HALF)) begin
                        state    <= RUN;
                        rate_cnt <= '0;
                    end
                end
                RUN: begin
                    rate_cnt <= strobe ? '0 : rate_cnt + 1'b1;
                    if (strobe) begin
                        dac_vld <= 1'b1;
                        if (fifo_empty) begin
                            dac_data  <= '0;
                            underflow <= 1'b1;
                            state     <= PRIME;
                        end else begin
                            dac_data <= fifo_rdata[DATA_W-1:0];
                            dac_last <= fifo_rdata[DATA_W];
                            if (fifo_rdata[DATA_W]) frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_dout_rx.sv
// tb/tb_fir_dout_rx.sv - randomized self-checking bench for fir_dout_rx against a queue-based model
module tb_fir_dout_rx;

    localparam int IN_W    = 24;
    localparam int DATA_W  = 16;
    localparam int FIFO_AW = 4;
    localparam int RATE    = 50;
    localparam int FNUM    = 8;
`ifdef FIR_DOUT_SAT_EN
    localparam logic [15:0] EXP_ROUND = 16'h0001;
    localparam bit          EXP_SAT   = 1'b1;
`else
    localparam logic [15:0] EXP_ROUND = 16'h0000;
    localparam bit          EXP_SAT   = 1'b0;
`endif

    logic              clk_100m = 1'b0;
    logic              rst = 1'b1;
    logic              fir_dout_vld = 1'b0;
    logic [IN_W-1:0]   fir_dout_data = '0;
    logic              fir_dout_last = 1'b0;
    logic              fir_dout_rdy;
    logic              dac_vld;
    logic [DATA_W-1:0] dac_data;
    logic              dac_last;
    logic [15:0]       frame_cnt;
    logic              underflow;
    logic              last_err;
    logic              sat_flag;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          acc;
    logic [16:0] exp_q[$];

    always #5 clk_100m = ~clk_100m;

    fir_dout_rx #(
        .IN_W(IN_W), .DATA_W(DATA_W), .FIFO_AW(FIFO_AW),
        .OUTPUT_DATA_RATE(RATE), .FRAME_NUM(FNUM)
    ) dut (
        .clk_100m(clk_100m), .rst(rst),
        .fir_dout_vld(fir_dout_vld), .fir_dout_data(fir_dout_data), .fir_dout_last(fir_dout_last),
        .fir_dout_rdy(fir_dout_rdy),
        .dac_vld(dac_vld), .dac_data(dac_data), .dac_last(dac_last),
        .frame_cnt(frame_cnt), .underflow(underflow), .last_err(last_err), .sat_flag(sat_flag)
    );

    // Expected DAC sample: floor(d/256), or floor((d+128)/256) clipped to 16-bit signed range.
    function automatic logic [15:0] model_conv(input logic [23:0] d, output bit clip);
        int v;
        v = int'($signed(d));
`ifdef FIR_DOUT_SAT_EN
        v = (v + 128) >>> 8;
        clip = (v > 32767) || (v < -32768);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`else
        v = v >>> 8;
        clip = 1'b0;
`endif
        return v[15:0];
    endfunction

    // One clock: inputs already driven are taken at the edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(negedge clk_100m);
        acc = fir_dout_vld && fir_dout_rdy;
        @(posedge clk_100m);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        fir_dout_vld = 1'b0;
        fir_dout_last = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        exp_q.delete();
    endtask

    task automatic send(input logic [23:0] d, input logic l);
        bit c;
        fir_dout_vld = 1'b1;
        fir_dout_data = d;
        fir_dout_last = l;
        for (int t = 0; t < 40 * RATE; t++) begin
            step();
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data %h never accepted", d);
        end else begin
            exp_q.push_back({l, model_conv(d, c)});
        end
        fir_dout_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (fir_dout_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", fir_dout_rdy); end
        checks++;
        if ({dac_vld, dac_last, underflow, last_err, sat_flag} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000", {dac_vld, dac_last, underflow, last_err, sat_flag});
        end
        checks++;
        if ({dac_data, frame_cnt} !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", {dac_data, frame_cnt}); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({fir_dout_rdy, dac_vld, underflow, last_err} !== 4'b1000) begin
                errors++; $display("FAIL reset_release got %b want 1000", {fir_dout_rdy, dac_vld, underflow, last_err});
            end
        end
    endtask

    task automatic test_prime_rate();
        int k8;
        int n;
        logic [16:0] e;
        do_reset();
        for (int k = 1; k <= 8; k++) send(24'((k << 8) | $urandom_range(0, 255)), k == 8);
        k8 = cyc;
        n = 0;
        for (int t = 0; t < 10 * RATE && n < 9; t++) begin
            step();
            checks++;
            if (last_err !== 1'b0) begin errors++; $display("FAIL prime_last_err got %b want 0", last_err); end
            if (dac_vld) begin
                checks++;
                if (cyc !== k8 + 1 + RATE * (n + 1)) begin
                    errors++; $display("FAIL prime_timing out %0d at cycle %0d want %0d", n, cyc, k8 + 1 + RATE * (n + 1));
                end
                checks++;
                if (n < 8) begin
                    e = exp_q.pop_front();
                    if ({dac_last, dac_data} !== e || underflow !== 1'b0) begin
                        errors++; $display("FAIL prime_data out %0d got %h uf %b want %h uf 0", n, {dac_last, dac_data}, underflow, e);
                    end
                    if (n == 7) begin
                        checks++;
                        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL prime_frame_cnt got %0d want 1", frame_cnt); end
                    end
                end else if ({dac_last, dac_data, underflow} !== 18'h1) begin
                    errors++; $display("FAIL prime_underflow got last %b data %h uf %b want 0 0 1", dac_last, dac_data, underflow);
                end
                n++;
            end
        end
        checks++;
        if (n !== 9) begin errors++; $display("FAIL prime_count got %0d outputs want 9", n); end
        // Seven beats are below the priming threshold: no output may appear.
        for (int k = 0; k < 7; k++) send(24'($urandom), 1'b0);
        for (int t = 0; t < 3 * RATE; t++) begin
            step();
            checks++;
            if (dac_vld !== 1'b0) begin errors++; $display("FAIL reprime_early dac_vld got 1 want 0 at cycle %0d", cyc); end
        end
        send(24'($urandom), 1'b1);
        k8 = cyc;
        for (int t = 0; t < 2 * RATE + 5 && !dac_vld; t++) step();
        checks++;
        if (dac_vld !== 1'b1 || cyc !== k8 + 1 + RATE) begin
            errors++; $display("FAIL reprime_timing got vld %b at cycle %0d want 1 at %0d", dac_vld, cyc, k8 + 1 + RATE);
        end
        checks++;
        e = exp_q.pop_front();
        if ({dac_last, dac_data} !== e) begin errors++; $display("FAIL reprime_data got %h want %h", {dac_last, dac_data}, e); end
    endtask

    task automatic test_backpressure();
        logic [23:0] beats [20];
        int i;
        int outs;
        int blocked_at;
        int last_out;
        bit c;
        logic [16:0] e;
        do_reset();
        for (int k = 0; k < 20; k++) beats[k] = 24'($urandom);
        i = 0;
        outs = 0;
        blocked_at = -1;
        last_out = -1;
        for (int t = 0; t < 30 * RATE && outs < 20; t++) begin
            fir_dout_vld = (i < 20);
            fir_dout_data = (i < 20) ? beats[i] : '0;
            fir_dout_last = (i == 7) || (i == 15);
            step();
            if (fir_dout_vld && !acc && blocked_at < 0) blocked_at = i;
            if (acc) begin
                exp_q.push_back({fir_dout_last, model_conv(beats[i], c)});
                i++;
            end
            if (dac_vld) begin
                checks++;
                e = exp_q.pop_front();
                if (underflow !== 1'b0 || {dac_last, dac_data} !== e) begin
                    errors++; $display("FAIL bp_data out %0d got %h uf %b want %h uf 0", outs, {dac_last, dac_data}, underflow, e);
                end
                if (last_out >= 0) begin
                    checks++;
                    if (cyc - last_out !== RATE) begin errors++; $display("FAIL bp_spacing got %0d want %0d", cyc - last_out, RATE); end
                end
                last_out = cyc;
                outs++;
            end
            checks++;
            if (fir_dout_rdy !== (i - outs != 16) || last_err !== 1'b0) begin
                errors++; $display("FAIL bp_rdy got rdy %b err %b want rdy %b err 0", fir_dout_rdy, last_err, (i - outs != 16));
            end
        end
        fir_dout_vld = 1'b0;
        checks++;
        if (blocked_at !== 16) begin errors++; $display("FAIL bp_block_point got %0d want 16", blocked_at); end
        checks++;
        if (outs !== 20) begin errors++; $display("FAIL bp_outputs got %0d want 20", outs); end
        checks++;
        if (frame_cnt !== 16'd2) begin errors++; $display("FAIL bp_frame_cnt got %0d want 2", frame_cnt); end
    endtask

    task automatic test_framing();
        // Beats 0-5: last on 5 (early); 6-13: correct frame; 14-21: missing last; 22: last at position 0.
        int n;
        bit exp_err;
        do_reset();
        n = 0;
        for (int t = 0; t < 40 * RATE && n < 23; t++) begin
            fir_dout_vld = 1'b1;
            fir_dout_data = 24'($urandom);
            fir_dout_last = (n == 5) || (n == 13) || (n == 22);
            step();
            exp_err = acc && (n == 5 || n == 21 || n == 22);
            checks++;
            if (last_err !== exp_err) begin errors++; $display("FAIL framing beat %0d last_err got %b want %b", n, last_err, exp_err); end
            if (acc) n++;
        end
        fir_dout_vld = 1'b0;
        checks++;
        if (n !== 23) begin errors++; $display("FAIL framing_accepts got %0d want 23", n); end
    endtask

    task automatic test_reset_mid_run();
        int k8;
        int n;
        logic [16:0] e;
        do_reset();
        for (int k = 0; k < 8; k++) send(24'($urandom), k == 7);
        n = 0;
        for (int t = 0; t < 5 * RATE && n < 3; t++) begin
            step();
            if (dac_vld) n++;
        end
        for (int k = 0; k < 3; k++) send(24'($urandom), 1'b0);
        rst = 1'b1;
        step();
        checks++;
        if ({fir_dout_rdy, dac_vld, dac_last, underflow, last_err, sat_flag, dac_data, frame_cnt} !== 38'h0) begin
            errors++; $display("FAIL midrst_outputs got rdy %b vld %b data %h fc %0d want all 0", fir_dout_rdy, dac_vld, dac_data, frame_cnt);
        end
        rst = 1'b0;
        for (int t = 0; t < 3 * RATE; t++) begin
            step();
            checks++;
            if (dac_vld !== 1'b0) begin errors++; $display("FAIL midrst_idle dac_vld got 1 want 0 at cycle %0d", cyc); end
        end
        exp_q.delete();
        for (int k = 0; k < 8; k++) send(24'($urandom), k == 7);
        k8 = cyc;
        checks++;
        if (last_err !== 1'b0) begin errors++; $display("FAIL midrst_rx_cnt last_err got 1 want 0"); end
        for (int t = 0; t < 2 * RATE + 5 && !dac_vld; t++) step();
        checks++;
        e = exp_q.pop_front();
        if (dac_vld !== 1'b1 || cyc !== k8 + 1 + RATE || {dac_last, dac_data} !== e) begin
            errors++; $display("FAIL midrst_first got vld %b cyc %0d data %h want 1 %0d %h", dac_vld, cyc, {dac_last, dac_data}, k8 + 1 + RATE, e);
        end
    endtask

    task automatic test_sat();
        do_reset();
        send(24'h000080, 1'b0);
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_round_flag got %b want 0", sat_flag); end
        send(24'h7FFFF0, 1'b0);
        checks++;
        if (sat_flag !== EXP_SAT) begin errors++; $display("FAIL sat_clip_flag got %b want %b", sat_flag, EXP_SAT); end
        for (int k = 0; k < 6; k++) send(24'($urandom_range(0, 24'h3FFFFF)), k == 5);
        for (int t = 0; t < 3 * RATE && !dac_vld; t++) step();
        checks++;
        if (dac_vld !== 1'b1 || dac_data !== EXP_ROUND) begin
            errors++; $display("FAIL sat_round_out got vld %b data %h want 1 %h", dac_vld, dac_data, EXP_ROUND);
        end
        step();
        for (int t = 0; t < 2 * RATE && !dac_vld; t++) step();
        checks++;
        if (dac_vld !== 1'b1 || dac_data !== 16'h7FFF) begin
            errors++; $display("FAIL sat_clip_out got vld %b data %h want 1 7fff", dac_vld, dac_data);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_prime_rate();
        test_backpressure();
        test_framing();
        test_reset_mid_run();
        test_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
